fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the program counter logic and the instruction memory port.
- Owns the fetch address and issues one memory request at a time over a req/gnt/rvalid handshake.
- Buffers returned instructions, each tagged with its PC, in a small FIFO that drains to decode under valid/ready.
- Applies jump/branch redirects, discarding stale in-flight responses and flushing buffered instructions.

---
 rtl/fetch_ctrl_if.sv | 51 +++++
 rtl/fetch_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bundle of the fetch controller's handshake signals. It carries
//               the redirect input, the instruction-memory req/gnt/rvalid port
//               and the decode-side valid/ready port.
//               master : the fetch controller (drives req/addr and the decode
//                        head signals, receives redirect/gnt/rvalid/ready).
//               slave  : the surrounding pipeline and memory.
// Signals     : redirect_i, redirect_addr_i   taken jump/branch and its target
//               instr_req_o, instr_addr_o     memory request and its address
//               instr_gnt_i                   request accepted this cycle
//               instr_rvalid_i, instr_rdata_i read data and its valid
//               instr_valid_o, instr_o,       FIFO head presented to decode
//               instr_pc_o
//               instr_ready_i                 decode accepts the head
//               busy_o                        a request is outstanding
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned INSTR_WIDTH = 32
) ();
   logic                   redirect_i;
   logic [ADDR_WIDTH-1:0]  redirect_addr_i;
   logic                   instr_req_o;
   logic [ADDR_WIDTH-1:0]  instr_addr_o;
   logic                   instr_gnt_i;
   logic                   instr_rvalid_i;
   logic [INSTR_WIDTH-1:0] instr_rdata_i;
   logic                   instr_valid_o;
   logic [INSTR_WIDTH-1:0] instr_o;
   logic [ADDR_WIDTH-1:0]  instr_pc_o;
   logic                   instr_ready_i;
   logic                   busy_o;

   modport master (
      input  redirect_i, redirect_addr_i, instr_gnt_i, instr_rvalid_i,
             instr_rdata_i, instr_ready_i,
      output instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o,
             busy_o
   );

   modport slave (
      output redirect_i, redirect_addr_i, instr_gnt_i, instr_rvalid_i,
             instr_rdata_i, instr_ready_i,
      input  instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o,
             busy_o
   );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the fetch address, issues a
//               single outstanding request over req/gnt/rvalid, buffers
//               returned instructions tagged with their PC in a small FIFO
//               drained by decode under valid/ready, and applies redirects by
//               flushing the FIFO and discarding stale in-flight responses.
// Ports       : clk           clock
//               rst_n         synchronous, active-low reset
//               bus           fetch_ctrl_if.master (memory + decode + redirect)
//               stall_cnt_o   (FETCH_PERF_CNT_EN only) saturating count of
//                             IDLE cycles and ungranted REQ cycles
//               discard_cnt_o (FETCH_PERF_CNT_EN only) saturating count of
//                             dropped responses
// Options     : define FETCH_PERF_CNT_EN to add the two performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
   parameter int unsigned          ADDR_WIDTH  = 32,
   parameter int unsigned          INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
   parameter int unsigned          BUF_DEPTH   = 2
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   fetch_ctrl_if.master   bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]    stall_cnt_o,
   output logic [31:0]    discard_cnt_o
`endif
);

   localparam int unsigned c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_WAIT    = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_fetch_addr, w_fetch_addr_nxt;
   logic [ADDR_WIDTH-1:0]   r_pending_pc;
   logic                    w_latch_pc, w_push, w_drop, w_pop;
   logic                    w_room, w_room_after_push;
   logic [ADDR_WIDTH-1:0]   w_redirect_addr;
   logic [c_CNT_W-1:0]      w_count_less_pop;

   logic [INSTR_WIDTH-1:0]  r_buf_instr [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0]   r_buf_pc    [BUF_DEPTH];
   logic [c_PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
   logic [c_CNT_W-1:0]      r_count;

   // Redirect targets are word aligned; the low bits are ignored.
   logic w_unused_addr_lsbs;
   assign w_unused_addr_lsbs = ^bus.redirect_addr_i[1:0];
   assign w_redirect_addr    = {bus.redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};

   // A redirect flushes the FIFO, so it also suppresses the pop.
   assign w_pop = (r_count != '0) && bus.instr_ready_i && !bus.redirect_i;

   // A new request is only issued when its response is guaranteed a slot.
   assign w_count_less_pop  = r_count - c_CNT_W'(w_pop);
   assign w_room            = w_count_less_pop < c_DEPTH;
   assign w_room_after_push = (w_count_less_pop + c_CNT_W'(1)) < c_DEPTH;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_REQ;
         r_fetch_addr <= RESET_ADDR;
         r_pending_pc <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_addr <= w_fetch_addr_nxt;
         if (w_latch_pc) r_pending_pc <= r_fetch_addr;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_fetch_addr_nxt = r_fetch_addr;
      w_latch_pc       = 1'b0;
      w_push           = 1'b0;
      w_drop           = 1'b0;

      // Any redirect retargets the fetch address, whatever the state.
      if (bus.redirect_i) w_fetch_addr_nxt = w_redirect_addr;

      case (r_state)
         S_IDLE: begin
            if (bus.redirect_i || w_room) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (bus.instr_gnt_i) begin
               if (bus.redirect_i) begin
                  w_state_nxt = S_DISCARD;
               end else begin
                  w_latch_pc       = 1'b1;
                  w_fetch_addr_nxt = r_fetch_addr + ADDR_WIDTH'(4);
                  w_state_nxt      = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.instr_rvalid_i) begin
               if (bus.redirect_i) begin
                  w_drop      = 1'b1;
                  w_state_nxt = S_REQ;
               end else begin
                  w_push      = 1'b1;
                  w_state_nxt = w_room_after_push ? S_REQ : S_IDLE;
               end
            end else if (bus.redirect_i) begin
               w_state_nxt = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (bus.instr_rvalid_i) begin
               w_drop      = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   assign bus.instr_req_o  = (r_state == S_REQ);
   assign bus.instr_addr_o = r_fetch_addr;
   assign bus.busy_o       = (r_state == S_WAIT) || (r_state == S_DISCARD);

   // ------------------------------------------------------------------
   // Prefetch FIFO: decode sees only registered storage, never rdata.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            r_buf_instr[i] <= '0;
            r_buf_pc[i]    <= '0;
         end
      end else if (bus.redirect_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_buf_instr[r_wr_ptr] <= bus.instr_rdata_i;
            r_buf_pc[r_wr_ptr]    <= r_pending_pc;
            r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   assign bus.instr_valid_o = (r_count != '0);
   assign bus.instr_o       = r_buf_instr[r_rd_ptr];
   assign bus.instr_pc_o    = r_buf_pc[r_rd_ptr];

`ifdef FETCH_PERF_CNT_EN
   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   logic [31:0] r_stall_cnt, r_discard_cnt;
   logic        w_stall;

   assign w_stall = (r_state == S_IDLE) ||
                    ((r_state == S_REQ) && !bus.instr_gnt_i);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt   <= '0;
         r_discard_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_drop && (r_discard_cnt != '1))
            r_discard_cnt <= r_discard_cnt + 32'd1;
      end
   end

   assign stall_cnt_o   = r_stall_cnt;
   assign discard_cnt_o = r_discard_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A cycle-stepped memory
//               model answers requests with data derived from the address; a
//               scoreboard queue holds the PCs expected at the decode port and
//               is compared whenever decode accepts the FIFO head. A table of
//               redirect vectors covers alignment and address wrap.
// Options     : define FETCH_PERF_CNT_EN to also check the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
   localparam int unsigned AW = 32;
   localparam int unsigned IW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus_if ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt, discard_cnt;
`endif

   fetch_ctrl #(
      .ADDR_WIDTH (AW),
      .INSTR_WIDTH(IW),
      .RESET_ADDR (32'h0000_0000),
      .BUF_DEPTH  (2)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus_if)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt_o  (stall_cnt),
      .discard_cnt_o(discard_cnt)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [AW-1:0] sb_q[$];

   typedef struct {
      logic [AW-1:0] redir;
      logic [AW-1:0] exp_a0;
      logic [AW-1:0] exp_a1;
   } vec_t;
   vec_t vecs[4];

   function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
      return a ^ 32'hC0DE_F00D;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Score the decode handshake of the current cycle, then advance one clock.
   task automatic step();
      logic [AW-1:0] e;
      if (bus_if.redirect_i) begin
         sb_q.delete();
      end else if (bus_if.instr_valid_o && bus_if.instr_ready_i) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got pc 0x%0h with nothing expected",
                     bus_if.instr_pc_o);
         end else begin
            e = sb_q.pop_front();
            chk("head_pc", bus_if.instr_pc_o, e);
            chk("head_instr", bus_if.instr_o, mem_data(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Expect a request for address a, grant it, answer it one cycle later.
   task automatic fetch_one(input logic [AW-1:0] a);
      chk("req", bus_if.instr_req_o, 1);
      chk("req_addr", bus_if.instr_addr_o, a);
      bus_if.instr_gnt_i = 1'b1;
      step();
      bus_if.instr_gnt_i = 1'b0;
      chk("busy_wait", bus_if.busy_o, 1);
      bus_if.instr_rvalid_i = 1'b1;
      bus_if.instr_rdata_i  = mem_data(a);
      sb_q.push_back(a);
      step();
      bus_if.instr_rvalid_i = 1'b0;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
      vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[2] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};
      vecs[3] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};

      bus_if.redirect_i      = 1'b0;
      bus_if.redirect_addr_i = '0;
      bus_if.instr_gnt_i     = 1'b0;
      bus_if.instr_rvalid_i  = 1'b0;
      bus_if.instr_rdata_i   = '0;
      bus_if.instr_ready_i   = 1'b1;
      rst_n = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_valid", bus_if.instr_valid_o, 0);
      chk("rst_busy", bus_if.busy_o, 0);
      chk("rst_instr", bus_if.instr_o, 0);
      chk("rst_pc", bus_if.instr_pc_o, 0);

      rst_n = 1'b1;
      step();

      // Streaming with zero-wait memory and decode always ready
      fetch_one(32'h0);
      fetch_one(32'h4);
      fetch_one(32'h8);
      step();
      chk("stream_drained", sb_q.size(), 0);

      // Decode stalled: two pushes fill the FIFO, then IDLE
      bus_if.instr_ready_i = 1'b0;
      fetch_one(32'hC);
      fetch_one(32'h10);
      for (int i = 0; i < 3; i++) begin
         chk("full_no_req", bus_if.instr_req_o, 0);
         step();
      end
      chk("full_valid", bus_if.instr_valid_o, 1);
      bus_if.instr_ready_i = 1'b1;
      step();
      bus_if.instr_ready_i = 1'b0;
      fetch_one(32'h14);
      chk("one_req_only", bus_if.instr_req_o, 0);
      bus_if.instr_ready_i = 1'b1;
      step();
      step();
      chk("stall_drained", sb_q.size(), 0);

      // Redirect while waiting on a response with data buffered
      bus_if.instr_ready_i = 1'b0;
      fetch_one(32'h18);
      chk("pre_redir_addr", bus_if.instr_addr_o, 32'h1C);
      bus_if.instr_gnt_i = 1'b1;
      step();
      bus_if.instr_gnt_i     = 1'b0;
      bus_if.redirect_i      = 1'b1;
      bus_if.redirect_addr_i = 32'h100;
      step();
      bus_if.redirect_i = 1'b0;
      chk("flush_valid", bus_if.instr_valid_o, 0);
      chk("discard_busy", bus_if.busy_o, 1);
      chk("discard_no_req", bus_if.instr_req_o, 0);
      bus_if.instr_rvalid_i = 1'b1;
      bus_if.instr_rdata_i  = mem_data(32'h1C);
      step();
      bus_if.instr_rvalid_i = 1'b0;
      chk("stale_dropped", bus_if.instr_valid_o, 0);
      chk("discard_done", bus_if.busy_o, 0);
      bus_if.instr_ready_i = 1'b1;
      fetch_one(32'h100);
      step();
      chk("redir_drained", sb_q.size(), 0);

      // Redirect in the same cycle as the response
      bus_if.instr_gnt_i = 1'b1;
      step();
      bus_if.instr_gnt_i     = 1'b0;
      bus_if.redirect_i      = 1'b1;
      bus_if.redirect_addr_i = 32'h40;
      bus_if.instr_rvalid_i  = 1'b1;
      bus_if.instr_rdata_i   = mem_data(32'h104);
      step();
      bus_if.redirect_i     = 1'b0;
      bus_if.instr_rvalid_i = 1'b0;
      chk("wr_req", bus_if.instr_req_o, 1);
      chk("wr_addr", bus_if.instr_addr_o, 32'h40);
      chk("wr_valid", bus_if.instr_valid_o, 0);

      // Redirect table: ungranted REQ retarget, alignment and wrap
      for (int v = 0; v < 4; v++) begin
         bus_if.redirect_i      = 1'b1;
         bus_if.redirect_addr_i = vecs[v].redir;
         step();
         bus_if.redirect_i = 1'b0;
         chk("tbl_req_held", bus_if.instr_req_o, 1);
         fetch_one(vecs[v].exp_a0);
         chk("tbl_next_addr", bus_if.instr_addr_o, vecs[v].exp_a1);
         step();
      end

      // Redirect together with the grant: response must be discarded
      bus_if.instr_gnt_i     = 1'b1;
      bus_if.redirect_i      = 1'b1;
      bus_if.redirect_addr_i = 32'h300;
      step();
      bus_if.instr_gnt_i = 1'b0;
      bus_if.redirect_i  = 1'b0;
      chk("rg_busy", bus_if.busy_o, 1);
      chk("rg_no_req", bus_if.instr_req_o, 0);
      bus_if.instr_rvalid_i = 1'b1;
      bus_if.instr_rdata_i  = 32'hDEAD_BEEF;
      step();
      bus_if.instr_rvalid_i = 1'b0;
      chk("rg_valid", bus_if.instr_valid_o, 0);
      fetch_one(32'h300);
      step();
      chk("rg_drained", sb_q.size(), 0);

`ifdef FETCH_PERF_CNT_EN
      // Counters: five ungranted REQ cycles, then one dropped response
      rst_n = 1'b0;
      step();
      step();
      sb_q.delete();
      rst_n = 1'b1;
      chk("perf_rst_stall", stall_cnt, 0);
      chk("perf_rst_discard", discard_cnt, 0);
      repeat (5) step();
      chk("perf_stall5", stall_cnt, 5);
      bus_if.instr_gnt_i = 1'b1;
      step();
      bus_if.instr_gnt_i     = 1'b0;
      bus_if.instr_rvalid_i  = 1'b1;
      bus_if.redirect_i      = 1'b1;
      bus_if.redirect_addr_i = 32'h0;
      step();
      bus_if.instr_rvalid_i = 1'b0;
      bus_if.redirect_i     = 1'b0;
      chk("perf_stall", stall_cnt, 5);
      chk("perf_discard", discard_cnt, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
